// File: rtl/cache_repl_pkg.sv
// Shared types, sizes and FSM encoding for the 6-way replacement scheduler.
// Ages are kept as a packed per-set vector so a whole set updates in one write.
package cache_repl_pkg;
  localparam int WAYS            = 6;
  localparam int WAY_W           = 3;
  localparam int AGE_W           = 3;
  localparam int TIMEOUT_CYC_DEF = 255;

  typedef logic [AGE_W-1:0] age_t;
  typedef age_t [WAYS-1:0]  age_vec_t;
  typedef logic [2:0]       state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_CHOOSE    = 3'd1;
  localparam state_t ST_HOLD      = 3'd2;
  localparam state_t ST_WAIT_DONE = 3'd3;
  localparam state_t ST_UPDATE    = 3'd4;

  function automatic logic [WAYS-1:0] way_onehot(input logic [WAY_W-1:0] way);
    logic [WAYS-1:0] oh;
    oh = {WAYS{1'b0}};
    for (int i = 0; i < WAYS; i++) begin
      oh[i] = (way == WAY_W'(i)) ? 1'b1 : 1'b0;
    end
    return oh;
  endfunction

  // Way i starts with age i, so every set begins as a valid permutation.
  function automatic age_vec_t age_reset_vec();
    age_vec_t v;
    for (int i = 0; i < WAYS; i++) begin
      v[i] = AGE_W'(i);
    end
    return v;
  endfunction
endpackage

// File: rtl/cache_lru_age6.sv
// Combinational age-matrix LRU for one 6-way set: victim selection and
// the post-access age vector.
module cache_lru_age6
  import cache_repl_pkg::*;
(
  input  age_vec_t         ages,
  input  logic [WAYS-1:0]  way_valid,
  input  logic [WAY_W-1:0] acc_way,
  output logic [WAY_W-1:0] victim,
  output age_vec_t         ages_nxt
);

  logic             inv_found_s;
  logic [WAY_W-1:0] inv_way_s;
  logic [WAY_W-1:0] old_way_s;
  age_t             acc_age_s;

  // Victim pick: scanning downward lets the lowest matching index win.
  always_comb begin
    inv_found_s = 1'b0;
    inv_way_s   = {WAY_W{1'b0}};
    old_way_s   = {WAY_W{1'b0}};
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!way_valid[i]) begin
        inv_found_s = 1'b1;
        inv_way_s   = WAY_W'(i);
      end else begin
        inv_found_s = inv_found_s;
      end
      if (ages[i] == AGE_W'(WAYS - 1)) begin
        old_way_s = WAY_W'(i);
      end else begin
        old_way_s = old_way_s;
      end
    end
    if (inv_found_s) begin
      victim = inv_way_s;
    end else begin
      victim = old_way_s;
    end
  end

  // Old age of the accessed way.
  always_comb begin
    acc_age_s = {AGE_W{1'b0}};
    for (int i = 0; i < WAYS; i++) begin
      if (acc_way == WAY_W'(i)) begin
        acc_age_s = ages[i];
      end else begin
        acc_age_s = acc_age_s;
      end
    end
  end

  // Only ways younger than the accessed one age, so the values stay a permutation.
  always_comb begin
    ages_nxt = ages;
    for (int i = 0; i < WAYS; i++) begin
      if (acc_way == WAY_W'(i)) begin
        ages_nxt[i] = {AGE_W{1'b0}};
      end else if (ages[i] < acc_age_s) begin
        ages_nxt[i] = ages[i] + AGE_W'(1);
      end else begin
        ages_nxt[i] = ages[i];
      end
    end
  end

endmodule

// File: rtl/cache_victim_sched.sv
// Replacement scheduler: accepts lookup results, picks a victim on a miss and
// holds a one-hot select to the fill-path selector until its free returns.
module cache_victim_sched
  import cache_repl_pkg::*;
#(
  parameter int SETS        = 16,
  parameter int SET_W       = 4,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [SET_W-1:0] req_set,
  input  logic             req_hit,
  input  logic [WAY_W-1:0] req_hit_way,
  input  logic [WAYS-1:0]  way_valid,
  output logic [WAYS-1:0]  sel_valid,
  input  logic             sel_fire,
  input  logic             sel_done,
  output logic [WAY_W-1:0] victim_way,
  output logic             busy,
  output logic             err_timeout
);

  localparam int               TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic             accept_s;
  logic             hit_s;
  logic             choose_s;
  logic             upd_s;
  logic             waiting_s;
  logic             abort_s;
  logic [SET_W-1:0] set_r;
  logic [WAYS-1:0]  wvalid_r;
  logic [WAY_W-1:0] acc_way_r;
  logic [TMO_W-1:0] tmo_cnt_r;
  age_vec_t         age_r [SETS];
  age_vec_t         cur_age_s;
  age_vec_t         nxt_age_s;
  logic [WAY_W-1:0] pick_s;
  logic [WAYS-1:0]  sel_valid_r;
  logic [WAY_W-1:0] victim_r;
  logic             busy_r;
  logic             ready_r;
  logic             err_r;

  assign accept_s    = req_valid && ready_r;
  assign hit_s       = req_hit && (req_hit_way < WAY_W'(WAYS));
  assign cur_age_s   = age_r[set_r];
  assign req_ready   = ready_r;
  assign busy        = busy_r;
  assign sel_valid   = sel_valid_r;
  assign victim_way  = victim_r;
  assign err_timeout = err_r;

  cache_lru_age6 u_lru (
    .ages      (cur_age_s),
    .way_valid (wvalid_r),
    .acc_way   (acc_way_r),
    .victim    (pick_s),
    .ages_nxt  (nxt_age_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; the timeout abort outranks a late fire/done.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = hit_s ? ST_UPDATE : ST_CHOOSE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CHOOSE: state_nxt_s = ST_HOLD;
      ST_HOLD: begin
        if (abort_s) begin
          state_nxt_s = ST_IDLE;
        end else if (sel_fire && sel_done) begin
          state_nxt_s = ST_UPDATE;
        end else if (sel_fire) begin
          state_nxt_s = ST_WAIT_DONE;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      ST_WAIT_DONE: begin
        if (abort_s) begin
          state_nxt_s = ST_IDLE;
        end else if (sel_done) begin
          state_nxt_s = ST_UPDATE;
        end else begin
          state_nxt_s = ST_WAIT_DONE;
        end
      end
      ST_UPDATE: state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // State decodes that drive the datapath registers.
  always_comb begin
    choose_s  = (state_r == ST_CHOOSE);
    upd_s     = (state_r == ST_UPDATE);
    waiting_s = (state_r == ST_HOLD) || (state_r == ST_WAIT_DONE);
    abort_s   = waiting_s && (tmo_cnt_r == TMO_LAST);
  end

  // Capture, select hold, timeout counter and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      set_r       <= {SET_W{1'b0}};
      wvalid_r    <= {WAYS{1'b0}};
      acc_way_r   <= {WAY_W{1'b0}};
      tmo_cnt_r   <= {TMO_W{1'b0}};
      sel_valid_r <= {WAYS{1'b0}};
      victim_r    <= {WAY_W{1'b0}};
      busy_r      <= 1'b0;
      ready_r     <= 1'b1;
      err_r       <= 1'b0;
    end else begin
      ready_r <= (state_nxt_s == ST_IDLE);
      busy_r  <= (state_nxt_s != ST_IDLE);
      if (accept_s) begin
        set_r     <= req_set;
        wvalid_r  <= way_valid;
        acc_way_r <= hit_s ? req_hit_way : {WAY_W{1'b0}};
      end
      // The select only moves on entry to HOLD and on leaving the transaction.
      if (choose_s) begin
        acc_way_r   <= pick_s;
        victim_r    <= pick_s;
        sel_valid_r <= way_onehot(pick_s);
      end else if (upd_s || abort_s) begin
        victim_r    <= {WAY_W{1'b0}};
        sel_valid_r <= {WAYS{1'b0}};
      end
      if (choose_s) begin
        tmo_cnt_r <= {TMO_W{1'b0}};
      end else if (waiting_s) begin
        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
      end
      if (abort_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // Per-set age storage; written only in UPDATE, never on abort.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) begin
        age_r[s] <= age_reset_vec();
      end
    end else if (upd_s) begin
      age_r[set_r] <= nxt_age_s;
    end
  end

endmodule

// File: tb/tb_cache_victim_sched.sv
// Directed bench for cache_victim_sched: a table of lookups with hand-computed
// victims and ages, plus sequences for hold stability, fire+done, timeout and reset.
module tb_cache_victim_sched;
  import cache_repl_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_set;
  logic             req_hit;
  logic [2:0]       req_hit_way;
  logic [5:0]       way_valid;
  logic [5:0]       sel_valid;
  logic             sel_fire;
  logic             sel_done;
  logic [2:0]       victim_way;
  logic             busy;
  logic             err_timeout;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  set;
    logic        hit;
    logic [2:0]  hit_way;
    logic [5:0]  wv;
    logic        miss;
    logic [2:0]  vic;
    logic [5:0]  sel;
    logic [17:0] ages;
  } vec_t;

  vec_t vecs [9];

  cache_victim_sched dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_set     (req_set),
    .req_hit     (req_hit),
    .req_hit_way (req_hit_way),
    .way_valid   (way_valid),
    .sel_valid   (sel_valid),
    .sel_fire    (sel_fire),
    .sel_done    (sel_done),
    .victim_way  (victim_way),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Ages packed way5..way0, matching the set storage layout.
  function automatic logic [17:0] ag(input int a0, input int a1, input int a2,
                                     input int a3, input int a4, input int a5);
    return {3'(a5), 3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
  endfunction

  function automatic logic [17:0] set_ages(input int s);
    return dut.age_r[s];
  endfunction

  function automatic vec_t mk(input int s, input logic h, input int hw, input logic [5:0] wv,
                              input logic m, input int v, input logic [5:0] sl,
                              input logic [17:0] a);
    vec_t r;
    r.set = 4'(s); r.hit = h; r.hit_way = 3'(hw); r.wv = wv;
    r.miss = m; r.vic = 3'(v); r.sel = sl; r.ages = a;
    return r;
  endfunction

  task automatic send(input logic [3:0] s, input logic h, input logic [2:0] hw, input logic [5:0] wv);
    req_valid = 1'b1; req_set = s; req_hit = h; req_hit_way = hw; way_valid = wv;
    tick();
    req_valid = 1'b0;
    chk("accept_busy", 32'(busy), 32'd1);
    chk("accept_ready_low", 32'(req_ready), 32'd0);
  endtask

  task automatic pulse(input logic f, input logic d);
    sel_fire = f; sel_done = d;
    tick();
    sel_fire = 1'b0; sel_done = 1'b0;
  endtask

  initial begin
    logic       stable;
    logic [5:0] held;

    vecs[0] = mk(3,  1'b0, 0, 6'b111111, 1'b1, 5, 6'b100000, ag(1,2,3,4,5,0));
    vecs[1] = mk(0,  1'b0, 0, 6'b110101, 1'b1, 1, 6'b000010, ag(1,0,2,3,4,5));
    vecs[2] = mk(2,  1'b1, 4, 6'b111111, 1'b0, 0, 6'b000000, ag(1,2,3,4,0,5));
    vecs[3] = mk(3,  1'b0, 0, 6'b111111, 1'b1, 4, 6'b010000, ag(2,3,4,5,0,1));
    vecs[4] = mk(3,  1'b1, 7, 6'b111111, 1'b1, 3, 6'b001000, ag(3,4,5,0,1,2));
    vecs[5] = mk(5,  1'b1, 0, 6'b111111, 1'b0, 0, 6'b000000, ag(0,1,2,3,4,5));
    vecs[6] = mk(5,  1'b0, 0, 6'b000000, 1'b1, 0, 6'b000001, ag(0,1,2,3,4,5));
    vecs[7] = mk(7,  1'b0, 0, 6'b011111, 1'b1, 5, 6'b100000, ag(1,2,3,4,5,0));
    vecs[8] = mk(15, 1'b1, 2, 6'b111111, 1'b0, 0, 6'b000000, ag(1,2,0,3,4,5));

    rst = 1'b0; req_valid = 1'b0; req_set = 4'd0; req_hit = 1'b0; req_hit_way = 3'd0;
    way_valid = 6'd0; sel_fire = 1'b0; sel_done = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_sel", 32'(sel_valid), 32'd0);
    chk("rst_victim", 32'(victim_way), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    chk("rst_ages3", 32'(set_ages(3)), 32'(ag(0,1,2,3,4,5)));

    // Stray selector pulses while idle must do nothing.
    pulse(1'b1, 1'b1);
    chk("idle_pulse_busy", 32'(busy), 32'd0);
    chk("idle_pulse_sel", 32'(sel_valid), 32'd0);

    for (int i = 0; i < 9; i++) begin
      send(vecs[i].set, vecs[i].hit, vecs[i].hit_way, vecs[i].wv);
      if (!vecs[i].miss) begin
        chk("hit_sel_n1", 32'(sel_valid), 32'd0);
        tick();
        chk("hit_ready_n2", 32'(req_ready), 32'd1);
        chk("hit_sel_n2", 32'(sel_valid), 32'd0);
      end else begin
        chk("choose_sel_low", 32'(sel_valid), 32'd0);
        tick();
        chk("hold_sel", 32'(sel_valid), 32'(vecs[i].sel));
        chk("hold_victim", 32'(victim_way), 32'(vecs[i].vic));
        pulse(1'b1, 1'b0);
        tick();
        pulse(1'b0, 1'b1);
        chk("update_sel_held", 32'(sel_valid), 32'(vecs[i].sel));
        tick();
        chk("done_sel_clear", 32'(sel_valid), 32'd0);
        chk("done_ready", 32'(req_ready), 32'd1);
      end
      chk($sformatf("ages_vec%0d", i), 32'(set_ages(int'(vecs[i].set))), 32'(vecs[i].ages));
    end

    // Select held for 10 cycles between fire and done, with a repeated fire ignored.
    send(4'd1, 1'b0, 3'd0, 6'b111101);
    tick();
    chk("t2_sel", 32'(sel_valid), 32'h02);
    pulse(1'b1, 1'b0);
    stable = 1'b1;
    held = sel_valid;
    for (int k = 0; k < 10; k++) begin
      sel_fire = (k == 4) ? 1'b1 : 1'b0;
      tick();
      if (sel_valid !== held || victim_way !== 3'd1 || busy !== 1'b1) stable = 1'b0;
    end
    sel_fire = 1'b0;
    chk("t2_stable", 32'(stable), 32'd1);
    chk("t2_held_val", 32'(held), 32'h02);
    pulse(1'b0, 1'b1);
    tick();
    chk("t2_sel_clear", 32'(sel_valid), 32'd0);
    chk("t2_ages", 32'(set_ages(1)), 32'(ag(1,0,2,3,4,5)));

    // Fire and done together in HOLD.
    send(4'd4, 1'b0, 3'd0, 6'b111111);
    tick();
    chk("t4_sel", 32'(sel_valid), 32'h20);
    pulse(1'b1, 1'b1);
    chk("t4_busy_update", 32'(busy), 32'd1);
    tick();
    chk("t4_sel_clear", 32'(sel_valid), 32'd0);
    chk("t4_ready", 32'(req_ready), 32'd1);
    chk("t4_ages", 32'(set_ages(4)), 32'(ag(1,2,3,4,5,0)));

    // Timeout: 255 cycles in HOLD without a fire.
    send(4'd6, 1'b0, 3'd0, 6'b111111);
    tick();
    for (int k = 0; k < 254; k++) tick();
    chk("t5_sel_before", 32'(sel_valid), 32'h20);
    chk("t5_err_before", 32'(err_timeout), 32'd0);
    tick();
    chk("t5_err", 32'(err_timeout), 32'd1);
    chk("t5_sel_clear", 32'(sel_valid), 32'd0);
    chk("t5_ready", 32'(req_ready), 32'd1);
    chk("t5_ages", 32'(set_ages(6)), 32'(ag(0,1,2,3,4,5)));
    send(4'd6, 1'b1, 3'd0, 6'b111111);
    tick();
    chk("t5_next_ready", 32'(req_ready), 32'd1);
    chk("t5_err_sticky", 32'(err_timeout), 32'd1);

    // Async reset while waiting for done.
    send(4'd8, 1'b0, 3'd0, 6'b111111);
    tick();
    pulse(1'b1, 1'b0);
    tick();
    chk("t6_sel_wait", 32'(sel_valid), 32'h20);
    #2 rst = 1'b0;
    #1;
    chk("t6_sel_async", 32'(sel_valid), 32'd0);
    chk("t6_busy_async", 32'(busy), 32'd0);
    chk("t6_ready_async", 32'(req_ready), 32'd1);
    chk("t6_err_async", 32'(err_timeout), 32'd0);
    chk("t6_ages3", 32'(set_ages(3)), 32'(ag(0,1,2,3,4,5)));
    tick();
    rst = 1'b1;
    tick();
    chk("t6_ages8", 32'(set_ages(8)), 32'(ag(0,1,2,3,4,5)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
